// File: rtl/cpu_out_pkg.sv
// Shared types and constants for the CPU output serializer slice.
// The serializer state enum, the default word width and the frame length helpers live here.
package cpu_out_pkg;

    localparam int DATA_W     = 3;
    localparam int FRAME_BITS = DATA_W + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } ser_state_t;

    // Clock cycles occupied by one complete frame: start bit, data bits, stop bit.
    function automatic int frame_cycles(input int data_w, input int bit_cycles);
        return (data_w + 2) * bit_cycles;
    endfunction

endpackage

// File: rtl/cpu_out_if.sv
// CPU-side word handshake plus serial line and status outputs of the serializer.
// The serializer sits on the slave modport; the CPU or bench drives the master modport.
interface cpu_out_if #(
    parameter int DATA_W = cpu_out_pkg::DATA_W,
    parameter int DEPTH  = 4
) ();

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              tx;
    logic              busy;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  tx,
        input  busy,
        input  count,
        input  overflow
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output tx,
        output busy,
        output count,
        output overflow
    );

endinterface

// File: rtl/cpu_out_fifo.sv
// Small word FIFO in front of the serializer, with occupancy count and full/empty flags.
// Read data is combinational from the head so the serializer can load a word on the pop edge.
module cpu_out_fifo #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              do_push;
    logic              do_pop;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

    // A full FIFO refuses a push even when a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push && reset) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural rollover.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    assign rd_data = mem[rd_ptr_reg];

endmodule

// File: rtl/cpu_out_serializer.sv
// Buffers CPU output words and sends each as a start/data/stop frame on tx, LSB first.
// A word waiting at the end of a stop bit starts the next frame directly, with no idle gap.
module cpu_out_serializer #(
    parameter int DATA_W     = cpu_out_pkg::DATA_W,
    parameter int DEPTH      = 4,
    parameter int BIT_CYCLES = 4
) (
    input  logic     clk,
    input  logic     reset,
    cpu_out_if.slave bus
);

    import cpu_out_pkg::*;

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int CYC_W  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BIDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    ser_state_t        state_reg;
    ser_state_t        state_next;
    logic [CYC_W-1:0]  cyc_reg;
    logic [CYC_W-1:0]  cyc_next;
    logic [BIDX_W-1:0] bit_reg;
    logic [BIDX_W-1:0] bit_next;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic              tx_reg;
    logic              tx_next;
    logic              overflow_reg;

    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              ready;
    logic              bit_end;

    // Not ready while reset is held so nothing is accepted into a FIFO being cleared.
    assign ready     = reset && !fifo_full;
    assign fifo_push = bus.in_valid && ready;

    cpu_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (bus.in_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bit_end = (cyc_reg == CYC_W'(BIT_CYCLES - 1));

    always_comb begin
        state_next = state_reg;
        cyc_next   = cyc_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        fifo_pop   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_rd_data;
                    cyc_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cyc_next   = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    cyc_next = cyc_reg + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cyc_next = '0;
                    if (bit_reg == BIDX_W'(DATA_W - 1)) begin
                        state_next = STOP;
                    end else begin
                        bit_next   = bit_reg + 1'b1;
                        shift_next = shift_reg >> 1;
                    end
                end else begin
                    cyc_next = cyc_reg + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cyc_next = '0;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_rd_data;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cyc_next = cyc_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // tx is decoded from the next state and registered so the line never glitches.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            cyc_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            cyc_reg   <= cyc_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_reg <= 1'b0;
        end else if (bus.in_valid && !ready) begin
            overflow_reg <= 1'b1;
        end
    end

    assign bus.in_ready = ready;
    assign bus.tx       = tx_reg;
    assign bus.busy     = (state_reg != IDLE);
    assign bus.count    = fifo_count;
    assign bus.overflow = overflow_reg;

endmodule

// File: tb/tb_cpu_out_serializer.sv
// Directed and random stimulus for cpu_out_serializer, checked every cycle against a
// queue-plus-frame-timer model of the FIFO and serial line.
module tb_cpu_out_serializer;

    localparam int DW    = 3;
    localparam int DEPTH = 4;
    localparam int BC    = 4;
    localparam int FL    = (DW + 2) * BC;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cpu_out_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

    cpu_out_serializer #(
        .DATA_W     (DW),
        .DEPTH      (DEPTH),
        .BIT_CYCLES (BC)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: queued words, the frame on the line and its elapsed cycle.
    logic [DW-1:0] q[$];
    bit            m_active = 1'b0;
    int            m_pos = 0;
    logic [DW-1:0] m_word = '0;
    bit            m_ovf = 1'b0;
    int            busy_cnt = 0;
    int            peak = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed=timeout expected=idle", tag);
    endtask

    function automatic logic exp_tx();
        int idx;
        if (!m_active) return 1'b1;
        idx = m_pos / BC;
        if (idx == 0) return 1'b0;
        if (idx <= DW) return m_word[idx-1];
        return 1'b1;
    endfunction

    task automatic tick();
        int sz;
        bit do_push;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_ovf    = 1'b0;
        end else begin
            sz      = q.size();
            do_push = bus.in_valid && (sz != DEPTH);
            if (bus.in_valid && sz == DEPTH) m_ovf = 1'b1;
            if (m_active && m_pos < FL - 1) begin
                m_pos++;
            end else if (sz > 0) begin
                m_word   = q.pop_front();
                m_pos    = 0;
                m_active = 1'b1;
                $display("frame start word=%0h queued=%0d t=%0t", m_word, q.size(), $time);
            end else begin
                m_active = 1'b0;
            end
            if (do_push) q.push_back(bus.in_data);
        end
        @(negedge clk);
        chk("tx", bus.tx, exp_tx());
        chk("busy", bus.busy, m_active);
        chk("count", bus.count, q.size());
        chk("in_ready", bus.in_ready, rst_n && (q.size() != DEPTH));
        chk("overflow", bus.overflow, m_ovf);
        if (bus.busy) busy_cnt++;
        if (int'(bus.count) > peak) peak = int'(bus.count);
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        tick();
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        bus.in_valid = 1'b0;
        while ((bus.busy || bus.count != 0) && guard < 500) begin
            tick();
            guard++;
        end
        if (guard >= 500) timeout_fail(tag);
    endtask

    initial begin
        logic [FL-1:0] seen;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst_n        = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("reset_in_ready", bus.in_ready, 1'b0);
        chk("reset_tx", bus.tx, 1'b1);
        rst_n = 1'b1;
        tick();
        chk("release_in_ready", bus.in_ready, 1'b1);

        // Single 3'b101 frame: start, 1, 0, 1, stop, each BC cycles
        drive(1'b1, 3'b101);
        drive(1'b0, 3'b000);
        for (int i = 0; i < FL; i++) begin
            seen[i] = bus.tx;
            tick();
        end
        chk("frame_101", seen, 20'hFF0F0);
        chk("idle_after_frame", bus.busy, 1'b0);

        // Three back-to-back frames
        busy_cnt = 0;
        peak     = 0;
        drive(1'b1, 3'b001);
        drive(1'b1, 3'b010);
        drive(1'b1, 3'b111);
        drain("drain_b2b");
        chk("b2b_peak", peak, 2);
        chk("b2b_busy_cycles", busy_cnt, 3 * FL);

        // Overfill during the first frame
        busy_cnt = 0;
        peak     = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, DW'($urandom_range(0, 7)));
            if (i == 4) chk("full_in_ready", bus.in_ready, 1'b0);
        end
        chk("ovf_set", bus.overflow, 1'b1);
        drain("drain_ovf");
        chk("ovf_peak", peak, DEPTH);
        chk("ovf_busy_cycles", busy_cnt, 5 * FL);
        chk("ovf_sticky", bus.overflow, 1'b1);

        // Push in the same cycle as a pop with two words queued
        drive(1'b1, 3'b011);
        drive(1'b1, 3'b110);
        drive(1'b1, 3'b100);
        bus.in_valid = 1'b0;
        repeat (FL - 2) tick();
        chk("pre_pop_count", bus.count, 2);
        drive(1'b1, 3'b010);
        chk("push_pop_count", bus.count, 2);
        drain("drain_pushpop");

        // Reset at cycle 7 of a frame with words queued
        drive(1'b1, 3'b101);
        drive(1'b1, 3'b011);
        drive(1'b1, 3'b110);
        bus.in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_tx", bus.tx, 1'b1);
        chk("midrst_count", bus.count, 0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_ovf", bus.overflow, 1'b0);
        rst_n    = 1'b1;
        busy_cnt = 0;
        repeat (2 * FL) tick();
        chk("midrst_no_frames", busy_cnt, 0);

        // Random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            rst_n        = ($urandom_range(0, 299) != 0);
            bus.in_valid = ($urandom_range(0, 99) < 12);
            bus.in_data  = DW'($urandom_range(0, 7));
            tick();
        end
        rst_n = 1'b1;
        drain("drain_random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_out_serializer.md
CPU_OUT_SERIALIZER -- requirements
Module: cpu_out_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 3: width of the CPU output word.
REQ-002 The block SHALL have parameter DEPTH, default 4: FIFO entries; power of two, 2 to 16.
REQ-003 The block SHALL have parameter BIT_CYCLES, default 4: clk cycles per serial bit; at least 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset), sampled on the clk rising edge.
REQ-006 The block SHALL have port in_data, input, DATA_W bits: the CPU output_data word.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data is offered this cycle.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the FIFO can accept a word.
REQ-009 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit: the serializer is not IDLE.
REQ-011 The block SHALL have port count, output, clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a word is offered while full.

Function
REQ-013 The block SHALL push a word when in_valid && in_ready, and SHALL drive in_ready = (count != DEPTH).
REQ-014 When the FIFO is full, the block SHALL NOT push, even if a pop occurs in the same cycle.
REQ-015 The block SHALL set overflow when in_valid && !in_ready, hold it until reset, and discard the offered word.
REQ-016 The serializer SHALL have states IDLE, START, DATA and STOP.
REQ-017 IDLE -> START SHALL happen on the edge where the serializer is IDLE and count > 0, popping the head word into a shift register on that edge.
REQ-018 START SHALL drive tx=0, DATA SHALL drive shift[0] (LSB first, DATA_W bits), STOP SHALL drive tx=1, and IDLE SHALL drive tx=1.
REQ-019 The serializer SHALL hold each bit for exactly BIT_CYCLES cycles, using an internal cycle counter and bit index.
REQ-020 One frame SHALL last (DATA_W+2)*BIT_CYCLES cycles; the default is 20.
REQ-021 STOP -> START SHALL happen directly when count > 0 at the end of STOP; otherwise STOP -> IDLE, giving back-to-back frames with no idle gap.
REQ-022 Latency: a word pushed into an empty FIFO with the serializer IDLE at edge k SHALL produce tx=0 after edge k+1.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-024 in_data SHALL be captured unmodified; no arithmetic is performed on data.

Reset
REQ-025 While reset=0 at an edge, the block SHALL clear the FIFO pointers and count to 0 and enter IDLE with tx=1, busy=0 and overflow=0.
REQ-026 A reset that occurs mid-frame SHALL abort the frame and discard all queued words; tx SHALL be 1 from the next cycle.
REQ-027 in_ready SHALL be 0 while reset is asserted and 1 from the first cycle after release.

Structure
REQ-028 Package cpu_out_pkg SHALL hold the serializer state enum, DATA_W and the FRAME_BITS = DATA_W+2 constant.
REQ-029 The FIFO SHALL be the sub-module cpu_out_fifo, with push/pop/full/empty/count ports; the serializer FSM SHALL live in cpu_out_serializer.

Verification
REQ-030 Reset, then push 3'b101 once -> tx after edge k+1 is 0 for 4 cycles, then 1,0,1 for 4 cycles each, then 1 for 4 cycles; busy is 0 after 20 cycles.
REQ-031 Push 3'b001, 3'b010 and 3'b111 back-to-back -> three contiguous 20-cycle frames with no idle gap; count peaks at 2.
REQ-032 Hold in_valid high for 6 cycles during the first frame (DEPTH=4) -> count reaches 4, in_ready goes 0, overflow goes 1, and exactly 5 frames are emitted (1 in flight plus 4 queued).
REQ-033 Assert reset=0 at cycle 7 of a frame -> tx=1, count=0, busy=0 and overflow=0 next cycle, and no further frames are emitted.
REQ-034 With the FIFO at count=2, push in the cycle the serializer pops -> count stays 2, and the words are emitted in push order.
